// File: rtl/ysyx_24090003_lsu.sv
// Load/store unit: a three-state handshake between the EXU, a single-beat memory bus and write-back.
// Alignment and funct3 checks happen at accept, so a faulting access never reaches the bus.
module ysyx_24090003_lsu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_wdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_mem_rdata,
    output logic [31:0] o_alu_result,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_ren;
    logic        r_wen;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_bad_f3;
    logic        w_misal;
    logic        w_err;
    logic        w_go_bus;

    function automatic logic [31:0] f_load_ext(input logic [2:0]  funct3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  f_load_ext = {{24{b[7]}}, b};
            3'b001:  f_load_ext = {{16{h[15]}}, h};
            3'b010:  f_load_ext = rdata;
            3'b100:  f_load_ext = {24'd0, b};
            3'b101:  f_load_ext = {16'd0, h};
            default: f_load_ext = 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] f_store_mask(input logic [1:0] size,
                                                input logic [1:0] off);
        case (size)
            2'b00:   f_store_mask = 4'b0001 << off;
            2'b01:   f_store_mask = 4'b0011 << {off[1], 1'b0};
            default: f_store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0]  size,
                                                 input logic [31:0] wdata);
        case (size)
            2'b00:   f_store_data = {4{wdata[7:0]}};
            2'b01:   f_store_data = {2{wdata[15:0]}};
            default: f_store_data = wdata;
        endcase
    endfunction

    // Legality is judged on the incoming request so the accept cycle already knows the path.
    always_comb begin
        w_bad_f3 = 1'b0;
        if (i_mem_ren && !i_mem_wen) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_bad_f3 = 1'b0;
                default:                                w_bad_f3 = 1'b1;
            endcase
        end else if (i_mem_wen && !i_mem_ren) begin
            w_bad_f3 = (i_funct3 > 3'b010);
        end
        w_misal  = ((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
        w_err    = (i_mem_ren && i_mem_wen) ||
                   ((i_mem_ren || i_mem_wen) && (w_bad_f3 || w_misal));
        w_go_bus = (i_mem_ren ^ i_mem_wen) && !w_err;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next = w_go_bus ? REQ : DONE;
            REQ:     if (i_bus_ack) w_next = DONE;
            DONE:    if (i_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_funct3 <= i_funct3;
                        r_addr   <= i_alu_result;
                        r_wdata  <= i_wdata;
                        r_ren    <= i_mem_ren;
                        r_wen    <= i_mem_wen;
                        r_err    <= w_err;
                        r_rdata  <= 32'd0;
                    end
                end
                REQ: begin
                    if (i_bus_ack && r_ren) begin
                        r_rdata <= f_load_ext(r_funct3, r_addr[1:0], i_bus_rdata);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs derive only from latched request fields, so they stay still while waiting for ack.
    assign o_ready      = (r_state == IDLE);
    assign o_valid      = (r_state == DONE);
    assign o_bus_req    = (r_state == REQ);
    assign o_bus_we     = o_bus_req && r_wen;
    assign o_bus_addr   = {r_addr[31:2], 2'b00};
    assign o_bus_wdata  = f_store_data(r_funct3[1:0], r_wdata);
    assign o_bus_wmask  = o_bus_we ? f_store_mask(r_funct3[1:0], r_addr[1:0]) : 4'b0000;
    assign o_err        = r_err;
    assign o_mem_rdata  = r_rdata;
    assign o_alu_result = r_addr;

endmodule

// File: tb/tb_ysyx_24090003_lsu.sv
// Bench for the LSU: directed corner transactions, reset abandonment and randomized traffic
// compared against a byte-level reference model of RV32I load/store behaviour.
module tb_ysyx_24090003_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_wdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_mem_rdata;
    logic [31:0] o_alu_result;
    logic        o_err;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_24090003_lsu dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mem_ren    (i_mem_ren),
        .i_mem_wen    (i_mem_wen),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_wdata      (i_wdata),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_mem_rdata  (o_mem_rdata),
        .o_alu_result (o_alu_result),
        .o_err        (o_err),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_wmask  (o_bus_wmask),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access size n bytes, lane offset addr%4, sign/zero extension by arithmetic.
    task automatic model(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata,
                         output logic err, output logic bus, output logic [3:0] mask,
                         output logic [31:0] bwd, output logic [31:0] rd);
        int          n;
        int          off;
        bit          legal;
        logic [63:0] v;
        n   = 1 << f3[1:0];
        off = int'(addr % 4);
        if (ren && !wen)      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else if (wen && !ren) legal = (f3 <= 2);
        else                  legal = 1'b1;
        err  = (ren && wen) || ((ren || wen) && (!legal || (addr % n) != 0));
        bus  = (ren != wen) && !err;
        mask = (bus && wen) ? 4'(((1 << n) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wdata[8*(i % n) +: 8];
        rd = 32'd0;
        if (bus && ren) begin
            v = 64'(rdata) >> (8 * off);
            if (n < 4) begin
                v = v & ((64'd1 << (8 * n)) - 64'd1);
                if (!f3[2] && v[8*n-1]) v = v - (64'd1 << (8 * n));
            end
            rd = v[31:0];
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic run(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ackd, input int rdyd,
                       input bit stray);
        logic        e_err, e_bus;
        logic [3:0]  e_mask;
        logic [31:0] e_bwd, e_rd;
        model(ren, wen, f3, addr, wdata, rdata, e_err, e_bus, e_mask, e_bwd, e_rd);
        chk("idle_ready", o_ready, 1);
        chk("idle_valid", o_valid, 0);
        chk("idle_req", o_bus_req, 0);
        if (stray) begin
            i_bus_ack   = 1'b1;
            i_bus_rdata = $urandom;
            @(negedge clk);
            i_bus_ack = 1'b0;
            chk("stray_idle_valid", o_valid, 0);
            chk("stray_idle_ready", o_ready, 1);
        end
        i_valid      = 1'b1;
        i_mem_ren    = ren;
        i_mem_wen    = wen;
        i_funct3     = f3;
        i_alu_result = addr;
        i_wdata      = wdata;
        i_ready      = 1'b0;
        @(negedge clk);
        i_valid      = 1'b0;
        i_alu_result = $urandom;
        i_wdata      = $urandom;
        if (e_bus) begin
            for (int j = 0; j <= ackd; j++) begin
                chk("req_bus_req", o_bus_req, 1);
                chk("req_addr", o_bus_addr, {addr[31:2], 2'b00});
                chk("req_we", o_bus_we, wen);
                chk("req_mask", o_bus_wmask, e_mask);
                if (wen) chk("req_wdata", o_bus_wdata, e_bwd);
                chk("req_valid", o_valid, 0);
                chk("req_ready", o_ready, 0);
                if (j == ackd) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = rdata;
                end
                @(negedge clk);
                i_bus_ack = 1'b0;
            end
        end else begin
            chk("nobus_req", o_bus_req, 0);
        end
        for (int k = 0; k <= rdyd; k++) begin
            chk("done_valid", o_valid, 1);
            chk("done_err", o_err, e_err);
            chk("done_rdata", o_mem_rdata, e_rd);
            chk("done_alu", o_alu_result, addr);
            chk("done_req", o_bus_req, 0);
            chk("done_we_mask", {o_bus_we, o_bus_wmask}, 0);
            chk("done_ready", o_ready, 0);
            i_ready     = (k == rdyd);
            i_bus_ack   = 1'($urandom);
            i_bus_rdata = $urandom;
            @(negedge clk);
            i_bus_ack = 1'b0;
        end
        i_ready = 1'b0;
        chk("after_valid", o_valid, 0);
        chk("after_ready", o_ready, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_valid      = 1'b0;
        i_mem_ren    = 1'b0;
        i_mem_wen    = 1'b0;
        i_funct3     = 3'd0;
        i_alu_result = 32'd0;
        i_wdata      = 32'd0;
        i_ready      = 1'b0;
        i_bus_ack    = 1'b0;
        i_bus_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_req", o_bus_req, 0);
        chk("rst_we_mask", {o_bus_we, o_bus_wmask}, 0);
        chk("rst_err", o_err, 0);
        chk("rst_rdata", o_mem_rdata, 0);
        chk("rst_alu", o_alu_result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corners
        run(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 0, 0);
        run(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 2, 1, 0);
        run(1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);
        run(1, 0, 3'b101, 32'h0000_0010, 32'h0, 32'hBEEF_1234, 4, 3, 0);
        run(0, 0, 3'b000, 32'h0000_002A, 32'h0, 32'h0, 0, 0, 0);
        run(1, 1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 1);
        run(0, 1, 3'b011, 32'h0000_0100, 32'h5555_AAAA, 32'h0, 0, 0, 0);
        run(0, 1, 3'b000, 32'h0000_0101, 32'hFFFF_FF5A, 32'h0, 1, 0, 0);

        // Reset while the bus request is outstanding
        i_valid      = 1'b1;
        i_mem_ren    = 1'b1;
        i_mem_wen    = 1'b0;
        i_funct3     = 3'b010;
        i_alu_result = 32'h0000_0100;
        @(negedge clk);
        i_valid = 1'b0;
        chk("rstreq_req_before", o_bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstreq_req", o_bus_req, 0);
        chk("rstreq_ready", o_ready, 1);
        chk("rstreq_valid", o_valid, 0);
        chk("rstreq_alu", o_alu_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        i_bus_ack = 1'b0;
        chk("rstreq_stray_valid", o_valid, 0);
        chk("rstreq_stray_ready", o_ready, 1);
        chk("rstreq_stray_req", o_bus_req, 0);
        @(negedge clk);
        chk("rstreq_stray_valid2", o_valid, 0);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [1:0] rw;
            rw = 2'($urandom_range(0, 3));
            run(rw[0], rw[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
